// File: rtl/control_div_if.sv
// Host-side bundle for the sequential divider: operands and start request in,
// results and status out.
interface control_div_if #(
  parameter int WIDTH = 16
);
  logic             init;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;

  modport master (
    output init, dividend, divisor,
    input  quotient, remainder, done, busy, div_by_zero
  );

  modport slave (
    input  init, dividend, divisor,
    output quotient, remainder, done, busy, div_by_zero
  );
endinterface

// File: rtl/control_div.sv
// Restoring shift-subtract divider, one quotient bit per SHIFT/CHECK(/SUB) pass; done after 2+2*WIDTH+ones(q) edges.
// Host holds init until done, then drops it to return to START; DIV_SIGNED_EN adds two's-complement operands via a FIX state.
module control_div #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  control_div_if.slave  bus
);

  localparam int AW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_CHECK = 3'd3,
    S_SUB   = 3'd4,
`ifdef DIV_SIGNED_EN
    S_FIX   = 3'd6,
`endif
    S_END   = 3'd5
  } state_t;

`ifdef DIV_SIGNED_EN
  localparam state_t S_LAST = S_FIX;
`else
  localparam state_t S_LAST = S_END;
`endif

  state_t           state_q, state_d;
  logic [AW-1:0]    a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic [AW-1:0]    b_ext;
  logic [AW-1:0]    diff;
`ifdef DIV_SIGNED_EN
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
`endif

  assign b_ext = {1'b0, b_q};
  assign diff  = a_q - b_ext;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    q_d         = q_q;
    b_d         = b_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
    sign_q_d    = sign_q_q;
    sign_r_d    = sign_r_q;
`endif

    case (state_q)
      S_START: begin
        if (bus.init) state_d = S_LOAD;
      end
      S_LOAD: begin
        a_d     = '0;
        count_d = CW'(WIDTH);
        dbz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
        // Magnitudes go through the unsigned datapath; |MIN| is MIN read as unsigned.
        q_d      = bus.dividend[WIDTH-1] ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
        b_d      = bus.divisor[WIDTH-1]  ? (~bus.divisor  + WIDTH'(1)) : bus.divisor;
        sign_q_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
        sign_r_d = bus.dividend[WIDTH-1];
`else
        q_d = bus.dividend;
        b_d = bus.divisor;
`endif
        if (bus.divisor == '0) begin
          state_d     = S_END;
          quotient_d  = '1;
          remainder_d = bus.dividend;
          dbz_d       = 1'b1;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {a_d, q_d} = {a_q, q_q} << 1;
        count_d    = count_q - CW'(1);
        state_d    = S_CHECK;
      end
      S_CHECK: begin
        if (a_q >= b_ext)        state_d = S_SUB;
        else if (count_q == '0)  state_d = S_LAST;
        else                     state_d = S_SHIFT;
      end
      S_SUB: begin
        a_d    = diff;
        q_d[0] = 1'b1;
        state_d = (count_q == '0) ? S_LAST : S_SHIFT;
      end
`ifdef DIV_SIGNED_EN
      S_FIX: begin
        q_d     = sign_q_q ? (~q_q + WIDTH'(1)) : q_q;
        a_d     = sign_r_q ? (~a_q + AW'(1)) : a_q;
        state_d = S_END;
      end
`endif
      S_END: begin
        if (!bus.init) state_d = S_START;
      end
      default: state_d = S_START;
    endcase

    // Results are captured once, on the edge that enters END from the iteration path.
    if (state_d == S_END && state_q != S_END && state_q != S_LOAD) begin
      quotient_d  = q_d;
      remainder_d = a_d[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_START;
      a_q         <= '0;
      q_q         <= '0;
      b_q         <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      b_q         <= b_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
      sign_q_q    <= sign_q_d;
      sign_r_q    <= sign_r_d;
`endif
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.done        = (state_q == S_END);
  assign bus.busy        = (state_q == S_LOAD) || (state_q == S_SHIFT) ||
                           (state_q == S_CHECK) || (state_q == S_SUB)
`ifdef DIV_SIGNED_EN
                           || (state_q == S_FIX)
`endif
                           ;

endmodule

// File: tb/tb_control_div.sv
// Directed bench for control_div at WIDTH=16: reset, latency, result patterns,
// divide-by-zero, ignored mid-operation inputs and (with DIV_SIGNED_EN) signed cases.
module tb_control_div;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  control_div_if #(.WIDTH(16)) bus();
  control_div #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an operation from START and waits (bounded) for done.
  task automatic run_div(input logic [15:0] a, input logic [15:0] b, output int edges);
    bus.dividend = a;
    bus.divisor  = b;
    bus.init     = 1'b1;
    edges        = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      edges++;
      if (bus.done) break;
    end
  endtask

  task automatic finish_op();
    bus.init = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.init = 1'b0;
    bus.dividend = 16'd0;
    bus.divisor  = 16'd0;
    tick();
    tick();
    rst = 1'b0;
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests++; if (bus.quotient !== 16'h0) begin fails++; $display("FAIL reset_quot got %h want 0", bus.quotient); end
    tests++; if (bus.remainder !== 16'h0) begin fails++; $display("FAIL reset_rem got %h want 0", bus.remainder); end
    tests++; if (bus.div_by_zero !== 1'b0) begin fails++; $display("FAIL reset_dbz got %b want 0", bus.div_by_zero); end
  endtask

  task automatic test_basic();
    int e;
    run_div(16'd100, 16'd7, e);
    tests++; if (e !== 37) begin fails++; $display("FAIL basic_latency got %0d want 37", e); end
    tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL basic_done got %b want 1", bus.done); end
    tests++; if (bus.quotient !== 16'd14) begin fails++; $display("FAIL basic_quot got %0d want 14", bus.quotient); end
    tests++; if (bus.remainder !== 16'd2) begin fails++; $display("FAIL basic_rem got %0d want 2", bus.remainder); end
    tick(); tick(); tick();
    tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL basic_done_hold got %b want 1", bus.done); end
    tests++; if (bus.quotient !== 16'd14) begin fails++; $display("FAIL basic_quot_hold got %0d want 14", bus.quotient); end
    finish_op();
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL basic_release_done got %b want 0", bus.done); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL basic_release_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_patterns();
    logic [15:0] a   [3] = '{16'hFFFF, 16'd5, 16'd9};
    logic [15:0] b   [3] = '{16'd1,    16'd9, 16'd9};
    logic [15:0] eq  [3] = '{16'hFFFF, 16'd0, 16'd1};
    logic [15:0] er  [3] = '{16'd0,    16'd5, 16'd0};
    int          lat [3] = '{50, 34, 35};
    int e;
    for (int i = 0; i < 3; i++) begin
      run_div(a[i], b[i], e);
      tests++; if (bus.quotient !== eq[i]) begin fails++; $display("FAIL pat%0d_quot got %h want %h", i, bus.quotient, eq[i]); end
      tests++; if (bus.remainder !== er[i]) begin fails++; $display("FAIL pat%0d_rem got %h want %h", i, bus.remainder, er[i]); end
      tests++; if (e !== lat[i]) begin fails++; $display("FAIL pat%0d_latency got %0d want %0d", i, e, lat[i]); end
      finish_op();
    end
  endtask

  task automatic test_div_zero();
    int e;
    run_div(16'd1234, 16'd0, e);
    tests++; if (e !== 2) begin fails++; $display("FAIL dbz_latency got %0d want 2", e); end
    tests++; if (bus.div_by_zero !== 1'b1) begin fails++; $display("FAIL dbz_flag got %b want 1", bus.div_by_zero); end
    tests++; if (bus.quotient !== 16'hFFFF) begin fails++; $display("FAIL dbz_quot got %h want ffff", bus.quotient); end
    tests++; if (bus.remainder !== 16'd1234) begin fails++; $display("FAIL dbz_rem got %0d want 1234", bus.remainder); end
    finish_op();
    bus.dividend = 16'd9;
    bus.divisor  = 16'd9;
    bus.init     = 1'b1;
    tick();
    tick();
    tests++; if (bus.div_by_zero !== 1'b0) begin fails++; $display("FAIL dbz_clear got %b want 0", bus.div_by_zero); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL dbz_next_busy got %b want 1", bus.busy); end
    for (int i = 0; i < 200; i++) begin
      if (bus.done) break;
      tick();
    end
    tests++; if (bus.quotient !== 16'd1) begin fails++; $display("FAIL dbz_next_quot got %0d want 1", bus.quotient); end
    finish_op();
  endtask

  task automatic test_ignore_inputs();
    int e = 2;
    int busy_bad = 0;
    bus.dividend = 16'd100;
    bus.divisor  = 16'd7;
    bus.init     = 1'b1;
    tick();
    tick();
    bus.dividend = 16'hABCD;
    bus.divisor  = 16'd0;
    for (int i = 0; i < 200; i++) begin
      bus.init = (i >= 20) ? 1'b1 : logic'(i % 2);
      tick();
      e++;
      if (bus.done) break;
      if (bus.busy !== 1'b1) busy_bad++;
    end
    tests++; if (busy_bad !== 0) begin fails++; $display("FAIL ign_busy got %0d idle cycles want 0", busy_bad); end
    tests++; if (e !== 37) begin fails++; $display("FAIL ign_latency got %0d want 37", e); end
    tests++; if (bus.quotient !== 16'd14) begin fails++; $display("FAIL ign_quot got %0d want 14", bus.quotient); end
    tests++; if (bus.remainder !== 16'd2) begin fails++; $display("FAIL ign_rem got %0d want 2", bus.remainder); end
    finish_op();
  endtask

  task automatic test_reset_mid();
    int e;
    run_div(16'd100, 16'd7, e);
    finish_op();
    bus.dividend = 16'd200;
    bus.divisor  = 16'd3;
    bus.init     = 1'b1;
    tick();
    tick();
    rst      = 1'b1;
    bus.init = 1'b0;
    tick();
    rst = 1'b0;
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL rstmid_done got %b want 0", bus.done); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    tests++; if (bus.quotient !== 16'd0) begin fails++; $display("FAIL rstmid_quot got %0d want 0", bus.quotient); end
    tests++; if (bus.remainder !== 16'd0) begin fails++; $display("FAIL rstmid_rem got %0d want 0", bus.remainder); end
    tick();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstmid_idle got %b want 0", bus.busy); end
    run_div(16'd200, 16'd3, e);
    tests++; if (bus.quotient !== 16'd66) begin fails++; $display("FAIL rstmid_quot2 got %0d want 66", bus.quotient); end
    tests++; if (bus.remainder !== 16'd2) begin fails++; $display("FAIL rstmid_rem2 got %0d want 2", bus.remainder); end
    finish_op();
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    logic [15:0] a  [3] = '{16'hFFF9, 16'd7,    16'h8000};
    logic [15:0] b  [3] = '{16'd2,    16'hFFFE, 16'hFFFF};
    logic [15:0] eq [3] = '{16'hFFFD, 16'hFFFD, 16'h8000};
    logic [15:0] er [3] = '{16'hFFFF, 16'd1,    16'd0};
    int e;
    for (int i = 0; i < 3; i++) begin
      run_div(a[i], b[i], e);
      tests++; if (bus.quotient !== eq[i]) begin fails++; $display("FAIL sgn%0d_quot got %h want %h", i, bus.quotient, eq[i]); end
      tests++; if (bus.remainder !== er[i]) begin fails++; $display("FAIL sgn%0d_rem got %h want %h", i, bus.remainder, er[i]); end
      finish_op();
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.init = 1'b0;
    bus.dividend = 16'd0;
    bus.divisor  = 16'd0;
    test_reset();
    test_basic();
    test_patterns();
    test_div_zero();
    test_ignore_inputs();
    test_reset_mid();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
